// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer.
// One full-adder cell is stepped LSB-first over WIDTH bits, one bit per clock,
// with the carry fed back through a register. A-B is computed as A + ~B + 1.
// Optional saturation of overflowed results: define SERIAL_ADDSUB_SAT_EN.
//
//   state | meaning
//   IDLE  | waiting for start; result/cout/overflow hold the last outcome
//   RUN   | one bit position processed per clock, LSB first
//   DONE  | one-cycle done pulse, then back to IDLE

module one_bit_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] PEN_IDX  = IW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             c_msb_q;
  logic             sum_bit, carry_bit;
  logic             accept, last_bit;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (idx_q == LAST_IDX);

  one_bit_adder u_fa (
    .x   (a_reg[idx_q]),
    .y   (b_reg[idx_q]),
    .cin (carry_q),
    .s   (sum_bit),
    .co  (carry_bit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // operand latch, serial datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_reg    <= a;
      b_reg    <= sub ? ~b : b;
      carry_q  <= sub;
      idx_q    <= '0;
      c_msb_q  <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state_q == RUN) begin
      result[idx_q] <= sum_bit;
      carry_q       <= carry_bit;
      idx_q         <= idx_q + IW'(1);
      // carry-out of bit WIDTH-2 is the carry into the MSB
      if (idx_q == PEN_IDX) c_msb_q <= carry_bit;
      if (last_bit) begin
        cout     <= carry_bit;
        overflow <= c_msb_q ^ carry_bit;
`ifdef SERIAL_ADDSUB_SAT_EN
        // saturate toward the sign of A; overrides the MSB bit write above
        if (c_msb_q ^ carry_bit) begin
          result <= a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (WIDTH = 9).
module tb_serial_addsub_ctrl;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   done_seen = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done with result 0x%0h, expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(result), int'(e.r));
        chk("cout", int'(cout), int'(e.c));
        chk("overflow", int'(overflow), int'(e.o));
      end
    end
  end

  // returns at the negedge where done is seen; lat = posedges after accept
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                        input logic [W-1:0] er, input logic ec, input logic eo);
    int lat, bcnt;
    @(posedge clk);
    #1 a = ta; b = tbv; sub = ts; start = 1'b1;
    @(posedge clk);
    sb.push_back('{r: er, c: ec, o: eo});
    #1 start = 1'b0; a = ~ta; b = ~tbv; sub = ~ts;
    wait_done(lat, bcnt);
    chk("latency", lat, W);
    chk("busy_cycles", bcnt, W);
    chk("busy_in_done", int'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("result_hold", int'(result), int'(er));
  endtask

  initial begin
    int lat, bcnt, dcnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_overflow", int'(overflow), 0);
    #1 rst_n = 1'b1;

    run_op(9'd100, 9'd27, 1'b0, 9'h07F, 1'b0, 1'b0);
    run_op(9'd100, 9'd27, 1'b1, 9'h049, 1'b1, 1'b0);
    run_op(9'd0,   9'd5,  1'b1, 9'h1FB, 1'b0, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
    run_op(9'd0,   9'h100, 1'b1, 9'h0FF, 1'b0, 1'b1);
    run_op(9'h0FF, 9'd1,   1'b0, 9'h0FF, 1'b0, 1'b1);
`else
    run_op(9'd0,   9'h100, 1'b1, 9'h100, 1'b0, 1'b1);
    run_op(9'h0FF, 9'd1,   1'b0, 9'h100, 1'b0, 1'b1);
`endif

    // start pulses while running and during DONE must be ignored
    @(posedge clk);
    #1 a = 9'd3; b = 9'd4; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    sb.push_back('{r: 9'd7, c: 1'b0, o: 1'b0});
    #1 start = 1'b0;
    fork
      wait_done(lat, bcnt);
      begin
        repeat (3) @(posedge clk);
        #1 a = 9'd50; b = 9'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    chk("ign_latency", lat, W);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_done_start_busy", int'(busy), 0);
    chk("ign_result_hold", int'(result), 7);
    run_op(9'd10, 9'd20, 1'b0, 9'd30, 1'b0, 1'b0);

    // reset in the middle of an operation
    @(posedge clk);
    #1 a = 9'd200; b = 9'd100; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_cout", int'(cout), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    dcnt = done_seen;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done", done_seen - dcnt, 0);
    run_op(9'd1, 9'd1, 1'b0, 9'd2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
